// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode constants, clog2 and even-parity helper shared by the FIFO files
package fifo_pkg;
  localparam int RD_MODE_REG = 0;
  localparam int RD_MODE_FWFT = 1;
  localparam int PAR_MAX_W = 1024;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  // Callers zero-extend to PAR_MAX_W; zero bits do not change the XOR.
  function automatic logic parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: FIFO storage, one synchronous write port and one asynchronous read port
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read). Contents are never reset.
module fifo_mem_2p import fifo_pkg::*; #(
  parameter int W = 8,
  parameter int D = 16,
  parameter int AW = clog2(D)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [D];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock parametrised FIFO with registered or first-word-fall-through read
// Ports: clk, reset (async, active-high), flush (sync clear), wr_en/din, rd_en/dout/dout_valid,
//   full/empty/almost_full/almost_empty/count status, sticky overflow/underflow, parity_err.
// Build option: define FIFO_PARITY_EN to store an even-parity bit per entry and check it on read.
module param_sync_fifo import fifo_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT = RD_MODE_REG,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  din,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic              parity_err
);
`ifdef FIFO_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [MW-1:0] wr_word, rd_word;
  logic rd_bad, wr_acc, rd_acc;
`ifdef FIFO_PARITY_EN
  assign wr_word = {parity(PAR_MAX_W'(din)), din};
  assign rd_bad = parity(PAR_MAX_W'(rd_word[WIDTH-1:0])) != rd_word[WIDTH];
`else
  assign wr_word = din;
  assign rd_bad = 1'b0;
`endif
  assign full = count == (ADDR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign almost_full = count >= (ADDR_W+1)'(AF_THRESH);
  assign almost_empty = count <= (ADDR_W+1)'(AE_THRESH);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;
  fifo_mem_2p #(.W(MW), .D(DEPTH), .AW(ADDR_W)) u_mem (
    .clk(clk), .we(wr_acc), .waddr(wr_ptr), .wdata(wr_word), .raddr(rd_ptr), .rdata(rd_word)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count <= (wr_acc && !rd_acc) ? count + 1'b1 : (rd_acc && !wr_acc) ? count - 1'b1 : count;
      overflow <= overflow | (wr_en & full);
      underflow <= underflow | (rd_en & empty);
    end
  if (FWFT == RD_MODE_FWFT) begin : g_fwft
    assign dout = rd_word[WIDTH-1:0];
    assign dout_valid = !empty;
    assign parity_err = !empty && rd_bad;
  end else begin : g_reg
    // dout keeps its last value across flush; only the qualifiers clear.
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        dout <= '0;
        dout_valid <= 1'b0;
        parity_err <= 1'b0;
      end else if (flush) begin
        dout_valid <= 1'b0;
        parity_err <= 1'b0;
      end else begin
        dout_valid <= rd_acc;
        parity_err <= rd_acc && rd_bad;
        if (rd_acc) dout <= rd_word[WIDTH-1:0];
      end
  end
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: scoreboard bench for param_sync_fifo in registered and FWFT read modes
module tb_param_sync_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic flush = 0, wr_en = 0, rd_en = 0;
  logic [7:0] din = 0, dout;
  logic dout_valid, full, empty, almost_full, almost_empty, overflow, underflow, parity_err;
  logic [4:0] count;
  logic f_flush = 0, f_wr_en = 0, f_rd_en = 0;
  logic [7:0] f_din = 0, f_dout;
  logic f_dout_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow, f_parity_err;
  logic [4:0] f_count;
  int checks = 0, failures = 0;
  logic [7:0] sb[$];
  logic [7:0] fsb[$];
  logic [7:0] exp;

  param_sync_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(0)) dut (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .parity_err(parity_err)
  );
  param_sync_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(1)) dut_f (
    .clk(clk), .reset(reset), .flush(f_flush), .wr_en(f_wr_en), .din(f_din), .rd_en(f_rd_en),
    .dout(f_dout), .dout_valid(f_dout_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow), .parity_err(f_parity_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush;
    flush = 1; tick; flush = 0;
    sb.delete();
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({count, dout} !== {5'd0, 8'h00}) begin
      failures++; $display("FAIL reset_count_dout got=%0d/%h exp=0/00", count, dout);
    end
    checks++;
    if ({full, empty, almost_full, almost_empty, overflow, underflow, dout_valid, parity_err} !== 8'b01010000) begin
      failures++; $display("FAIL reset_flags got=%b exp=01010000", {full, empty, almost_full, almost_empty, overflow, underflow, dout_valid, parity_err});
    end
    checks++;
    if ({f_count, f_empty, f_dout_valid} !== {5'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL reset_fwft got=%0d/%b/%b exp=0/1/0", f_count, f_empty, f_dout_valid);
    end
    tick;
    reset = 0;
    tick;
  endtask

  task automatic test_fill_overflow;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; din = 8'h11 + 8'(i); sb.push_back(din);
      tick;
      checks++;
      if (count !== 5'(i + 1)) begin
        failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i + 1);
      end
      checks++;
      if ({full, almost_full, almost_empty, overflow} !== {i == 15, i + 1 >= 14, i + 1 <= 2, 1'b0}) begin
        failures++; $display("FAIL fill_flags i=%0d got=%b exp=%b", i, {full, almost_full, almost_empty, overflow}, {i == 15, i + 1 >= 14, i + 1 <= 2, 1'b0});
      end
    end
    din = 8'hEE;
    tick;
    wr_en = 0;
    checks++;
    if ({count, full, overflow} !== {5'd16, 1'b1, 1'b1}) begin
      failures++; $display("FAIL overflow_write got=%0d/%b/%b exp=16/1/1", count, full, overflow);
    end
  endtask

  task automatic test_drain_underflow;
    for (int i = 0; i < 16; i++) begin
      rd_en = 1;
      tick;
      exp = sb.pop_front();
      checks++;
      if ({dout_valid, dout, count} !== {1'b1, exp, 5'(15 - i)}) begin
        failures++; $display("FAIL drain i=%0d got=%b/%h/%0d exp=1/%h/%0d", i, dout_valid, dout, count, exp, 15 - i);
      end
    end
    tick;
    rd_en = 0;
    checks++;
    if ({empty, underflow, dout_valid, dout, overflow} !== {1'b1, 1'b1, 1'b0, 8'h20, 1'b1}) begin
      failures++; $display("FAIL underflow got=%b/%b/%b/%h/%b exp=1/1/0/20/1", empty, underflow, dout_valid, dout, overflow);
    end
    do_flush;
    checks++;
    if ({overflow, underflow, dout, empty} !== {1'b0, 1'b0, 8'h20, 1'b1}) begin
      failures++; $display("FAIL flush_clear got=%b/%b/%h/%b exp=0/0/20/1", overflow, underflow, dout, empty);
    end
  endtask

  task automatic test_concurrent;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; din = 8'h30 + 8'(i); sb.push_back(din); tick;
    end
    for (int j = 0; j < 40; j++) begin
      wr_en = 1; rd_en = 1; din = 8'h40 + 8'(j); sb.push_back(din);
      tick;
      exp = sb.pop_front();
      checks++;
      if ({count, dout_valid, dout} !== {5'd8, 1'b1, exp}) begin
        failures++; $display("FAIL concurrent j=%0d got=%0d/%b/%h exp=8/1/%h", j, count, dout_valid, dout, exp);
      end
    end
    wr_en = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      exp = sb.pop_front();
      checks++;
      if ({dout_valid, dout} !== {1'b1, exp}) begin
        failures++; $display("FAIL concurrent_drain i=%0d got=%b/%h exp=1/%h", i, dout_valid, dout, exp);
      end
    end
    rd_en = 0;
    tick;
    checks++;
    if ({empty, dout_valid, overflow, underflow} !== 4'b1000) begin
      failures++; $display("FAIL concurrent_end got=%b exp=1000", {empty, dout_valid, overflow, underflow});
    end
  endtask

  task automatic test_full_both;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; din = 8'h50 + 8'(i); sb.push_back(din); tick;
    end
    rd_en = 1; din = 8'hDD;
    tick;
    wr_en = 0;
    exp = sb.pop_front();
    checks++;
    if ({count, overflow, dout_valid, dout} !== {5'd15, 1'b1, 1'b1, exp}) begin
      failures++; $display("FAIL full_both got=%0d/%b/%b/%h exp=15/1/1/%h", count, overflow, dout_valid, dout, exp);
    end
    for (int i = 0; i < 15; i++) begin
      tick;
      exp = sb.pop_front();
      checks++;
      if ({dout_valid, dout} !== {1'b1, exp}) begin
        failures++; $display("FAIL full_both_drain i=%0d got=%b/%h exp=1/%h", i, dout_valid, dout, exp);
      end
    end
    rd_en = 0;
    tick;
    checks++;
    if ({count, empty} !== {5'd0, 1'b1}) begin
      failures++; $display("FAIL full_both_end got=%0d/%b exp=0/1", count, empty);
    end
    do_flush;
  endtask

  task automatic test_empty_both;
    wr_en = 1; rd_en = 1; din = 8'h77; sb.push_back(din);
    tick;
    wr_en = 0; rd_en = 0;
    checks++;
    if ({count, underflow, dout_valid} !== {5'd1, 1'b1, 1'b0}) begin
      failures++; $display("FAIL empty_both got=%0d/%b/%b exp=1/1/0", count, underflow, dout_valid);
    end
    rd_en = 1;
    tick;
    rd_en = 0;
    exp = sb.pop_front();
    checks++;
    if ({dout_valid, dout, empty} !== {1'b1, exp, 1'b1}) begin
      failures++; $display("FAIL empty_both_read got=%b/%h/%b exp=1/%h/1", dout_valid, dout, empty, exp);
    end
    do_flush;
  endtask

  task automatic test_fwft;
    f_wr_en = 1; f_din = 8'hA5;
    tick;
    f_wr_en = 0;
    checks++;
    if ({f_dout_valid, f_dout, f_count} !== {1'b1, 8'hA5, 5'd1}) begin
      failures++; $display("FAIL fwft_first got=%b/%h/%0d exp=1/a5/1", f_dout_valid, f_dout, f_count);
    end
    f_rd_en = 1;
    tick;
    f_rd_en = 0;
    checks++;
    if ({f_empty, f_dout_valid} !== 2'b10) begin
      failures++; $display("FAIL fwft_pop got=%b/%b exp=1/0", f_empty, f_dout_valid);
    end
    for (int i = 0; i < 3; i++) begin
      f_wr_en = 1; f_din = 8'hB0 + 8'(i); fsb.push_back(f_din); tick;
    end
    f_wr_en = 0;
    for (int i = 0; i < 3; i++) begin
      exp = fsb.pop_front();
      checks++;
      if ({f_dout_valid, f_dout} !== {1'b1, exp}) begin
        failures++; $display("FAIL fwft_seq i=%0d got=%b/%h exp=1/%h", i, f_dout_valid, f_dout, exp);
      end
      f_rd_en = 1; tick; f_rd_en = 0;
    end
    checks++;
    if ({f_empty, f_dout_valid, f_underflow} !== 3'b100) begin
      failures++; $display("FAIL fwft_drained got=%b exp=100", {f_empty, f_dout_valid, f_underflow});
    end
  endtask

  task automatic test_flush;
    f_rd_en = 1; tick; f_rd_en = 0;
    for (int i = 0; i < 5; i++) begin
      f_wr_en = 1; f_din = 8'hC0 + 8'(i); tick;
    end
    checks++;
    if ({f_count, f_underflow} !== {5'd5, 1'b1}) begin
      failures++; $display("FAIL flush_pre got=%0d/%b exp=5/1", f_count, f_underflow);
    end
    f_flush = 1;
    tick;
    f_flush = 0; f_wr_en = 0;
    checks++;
    if ({f_count, f_empty, f_underflow, f_overflow, f_dout_valid} !== {5'd0, 4'b1000}) begin
      failures++; $display("FAIL flush_mid got=%0d/%b exp=0/1000", f_count, {f_empty, f_underflow, f_overflow, f_dout_valid});
    end
  endtask

  task automatic test_reset_mid_burst;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; din = 8'h60 + 8'(i); tick;
    end
    rd_en = 1; din = 8'h64;
    tick;
    checks++;
    if ({dout_valid, dout} !== {1'b1, 8'h60}) begin
      failures++; $display("FAIL burst_pre got=%b/%h exp=1/60", dout_valid, dout);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({count, dout, dout_valid, empty, full, overflow, underflow, parity_err} !== {5'd0, 8'h00, 6'b010000}) begin
      failures++; $display("FAIL reset_mid got=%0d/%h/%b exp=0/00/010000", count, dout, {dout_valid, empty, full, overflow, underflow, parity_err});
    end
    wr_en = 0; rd_en = 0;
    tick;
    reset = 0;
    sb.delete();
    tick;
  endtask

`ifdef FIFO_PARITY_EN
  task automatic test_parity;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; din = 8'h11 * 8'(i + 1); tick;
    end
    wr_en = 0;
    dut.u_mem.mem[0][0] = ~dut.u_mem.mem[0][0];
    for (int i = 0; i < 3; i++) begin
      rd_en = 1;
      tick;
      exp = (i == 0) ? 8'h10 : 8'h11 * 8'(i + 1);
      checks++;
      if ({dout_valid, dout, parity_err} !== {1'b1, exp, i == 0}) begin
        failures++; $display("FAIL parity i=%0d got=%b/%h/%b exp=1/%h/%b", i, dout_valid, dout, parity_err, exp, i == 0);
      end
    end
    rd_en = 0;
    tick;
    checks++;
    if (parity_err !== 1'b0) begin
      failures++; $display("FAIL parity_clear got=%b exp=0", parity_err);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_fill_overflow;
    test_drain_underflow;
    test_concurrent;
    test_full_both;
    test_empty_both;
    test_fwft;
    test_flush;
    test_reset_mid_burst;
`ifdef FIFO_PARITY_EN
    test_parity;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
